fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch controller sitting directly downstream of the PC register: consumes the PC value, issues one instruction-memory request per instruction, and buffers the returned word in a single-entry IF/ID register for decode. It produces the PC register's next value and load enable (sequential PC+4 or redirect target), so the PC register advances only when fetch or redirect allows. Throughput is one instruction per two cycles at best; branch/jump redirects take priority over all activity.

## Interface
- n, default 32: address/PC width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- pc_q  input  n  current PC (PC register Q).
- pc_d  output  n  next PC (PC register D).
- pc_load  output  1  PC register load enable.
- redirect  input  1  taken branch/jump from execute.
- redirect_target  input  n  redirect destination.
- mem_req  output  1  instruction memory request valid.
- mem_addr  output  n  request address.
- mem_ready  input  1  memory returns mem_rdata this cycle (completes request).
- mem_rdata  input  32  instruction word.
- id_valid  output  1  IF/ID buffer holds a valid instruction.
- id_ready  input  1  decode accepts buffer this cycle.
- id_inst  output  32  buffered instruction.
- id_pc  output  n  PC of buffered instruction.

## Operation
- States: IDLE, FETCH, HOLD, DROP. Internal: drop_addr [n-1:0].
- Reset (rst=0 at edge): state=IDLE, id_valid=0, id_inst=32'h00000013 (NOP), id_pc=0, drop_addr=0. While state=IDLE: mem_req=0, pc_load=0 unless redirect.
- pc_d: redirect_target with bits [1:0] forced to 00 when redirect=1, else pc_q+4 (modulo 2^n; 0xFFFFFFFC -> 0x00000000).
- IDLE: redirect -> pc_load=1, go FETCH; else go FETCH.
- FETCH: mem_req=1, mem_addr=pc_q.
  - redirect & mem_ready: response discarded, pc_load=1 (target), stay FETCH.
  - redirect & !mem_ready: pc_load=1 (target), drop_addr<=pc_q, go DROP.
  - mem_ready & !redirect: id_inst<=mem_rdata, id_pc<=pc_q, id_valid<=1, pc_load=1 (pc_q+4), go HOLD.
  - else: hold request, address stable (pc_load=0).
- HOLD: mem_req=0, id_valid=1.
  - redirect: id_valid<=0 (flush), pc_load=1 (target), go FETCH.
  - id_ready: id_valid<=0, go FETCH.
  - else stay; id_inst/id_pc stable.
- DROP: mem_req=1, mem_addr=drop_addr (request held stable to its original address). mem_ready -> discard word, go FETCH. Further redirect in DROP: pc_load=1 (new target), stay DROP until mem_ready.
- Redirect has priority over mem_ready and id_ready in every state.

## Timing
- pc_d, pc_load, mem_req, mem_addr: combinational from state and inputs; PC register updates at same edge that state advances.
- id_valid, id_inst, id_pc, state: registered.
- Latency: mem_ready in FETCH -> id_valid=1 next cycle. Best case sustained: 2 cycles/instruction (FETCH with mem_ready, HOLD with id_ready).
- Request rule: once mem_req=1 with an address, mem_req and mem_addr stay unchanged until mem_ready; redirect never withdraws a request (DROP).
- Reset mid-request: state -> IDLE at the edge; mem_req=0 the following cycle; id_valid cleared; in-flight response ignored.
- pc_load=0 whenever rst=0 is being applied (state forced IDLE at edge; PC register reset by same rst).

## Test plan
- Reset then pc_q=0x0, mem_ready=1 constant, id_ready=1: mem_addr 0x0,0x4,0x8 on alternating cycles; id_valid pulses with id_pc 0x0,0x4,0x8; pc_load high each FETCH cycle.
- Memory wait: mem_ready low 3 cycles in FETCH at pc 0x10: mem_req=1, mem_addr=0x10 all 4 cycles, pc_load=0 until mem_ready, then id_pc=0x10, pc_d=0x14.
- Decode stall: id_ready=0 for 5 cycles in HOLD: id_valid, id_inst, id_pc stable, mem_req=0, no pc_load.
- Redirect in HOLD to 0x103: id_valid clears next cycle, pc_d=0x100, next request at 0x100; redirect during pending request (FETCH, mem_ready=0) -> DROP keeps mem_addr at old PC until mem_ready, word discarded, then fetch 0x100.
- Wrap: pc_q=0xFFFFFFFC fetch completes -> pc_d=0x00000000.
- rst=0 asserted in FETCH with mem_ready low: next cycle mem_req=0, id_valid=0, id_inst=0x00000013, id_pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: drives the PC register, issues one memory request
// per instruction and buffers the returned word in a single-entry IF/ID register.
module fetch_unit #(
  parameter int unsigned n = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  pc_q,
  output logic [n-1:0]  pc_d,
  output logic          pc_load,
  input  logic          redirect,
  input  logic [n-1:0]  redirect_target,
  output logic          mem_req,
  output logic [n-1:0]  mem_addr,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_inst,
  output logic [n-1:0]  id_pc
);

  localparam logic [31:0] NopInst = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic [n-1:0]  id_pc_q, id_pc_d;
  logic [n-1:0]  drop_addr_q, drop_addr_d;

  // Next PC: word-aligned redirect target, else sequential.
  assign pc_d = redirect ? {redirect_target[n-1:2], 2'b00} : pc_q + n'(4);

  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;

  // Next-state and request/PC-load generation; redirect always wins.
  always_comb begin
    state_d     = state_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    drop_addr_d = drop_addr_q;
    pc_load     = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = pc_q;

    case (state_q)
      IDLE: begin
        pc_load = redirect;
        state_d = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (redirect) begin
          pc_load = 1'b1;
          if (!mem_ready) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (mem_ready) begin
          id_inst_d  = mem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_load    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          pc_load    = 1'b1;
          state_d    = FETCH;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      DROP: begin
        // Abandoned request stays on the bus until memory completes it.
        mem_req  = 1'b1;
        mem_addr = drop_addr_q;
        pc_load  = redirect;
        if (mem_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    if (!rst) pc_load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NopInst;
      id_pc_q     <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register model, a memory model and
// a scoreboard of instructions expected to reach decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_load;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_pc[$];

  always #5 clk = ~clk;

  fetch_unit #(.n(32)) dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .pc_d(pc_d), .pc_load(pc_load),
    .redirect(redirect), .redirect_target(redirect_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc)
  );

  // PC register downstream model
  always @(posedge clk) begin
    if (!rst) pc_q <= 32'h0;
    else if (pc_load) pc_q <= pc_d;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle;
    #1;
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb_pc.size() == 0) begin
        chk("sb_unexpected", id_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = sb_pc.pop_front();
        chk("sb_id_pc", id_pc, e);
        chk("sb_id_inst", id_inst, mem_word(e));
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    mem_ready = 1'b0; id_ready = 1'b0;
    tick(); tick();
    settle();
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_pc_load", 32'(pc_load), 32'h0);

    // IDLE after reset release
    rst = 1'b1;
    settle();
    chk("idle_mem_req", 32'(mem_req), 32'h0);
    chk("idle_pc_load", 32'(pc_load), 32'h0);
    tick();

    // Back-to-back fetch with fast memory and decode
    mem_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("seq_mem_req", 32'(mem_req), 32'h1);
      chk("seq_mem_addr", mem_addr, 32'(4 * i));
      chk("seq_pc_load", 32'(pc_load), 32'h1);
      chk("seq_pc_d", pc_d, 32'(4 * i + 4));
      sb_pc.push_back(32'(4 * i));
      tick();
      settle();
      chk("seq_id_valid", 32'(id_valid), 32'h1);
      chk("seq_hold_req", 32'(mem_req), 32'h0);
      chk("seq_hold_load", 32'(pc_load), 32'h0);
      tick();
    end

    // Redirect coinciding with mem_ready in FETCH: word discarded
    redirect = 1'b1; redirect_target = 32'h10;
    settle();
    chk("rdm_mem_addr", mem_addr, 32'hC);
    chk("rdm_pc_load", 32'(pc_load), 32'h1);
    chk("rdm_pc_d", pc_d, 32'h10);
    tick();
    redirect = 1'b0;

    // Memory wait at 0x10
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wait_mem_req", 32'(mem_req), 32'h1);
      chk("wait_mem_addr", mem_addr, 32'h10);
      chk("wait_pc_load", 32'(pc_load), 32'h0);
      chk("wait_id_valid", 32'(id_valid), 32'h0);
      tick();
    end
    mem_ready = 1'b1; id_ready = 1'b0;
    settle();
    chk("wait_done_addr", mem_addr, 32'h10);
    chk("wait_done_load", 32'(pc_load), 32'h1);
    chk("wait_done_pc_d", pc_d, 32'h14);
    sb_pc.push_back(32'h10);
    tick();

    // Decode stall in HOLD
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_id_valid", 32'(id_valid), 32'h1);
      chk("stall_id_pc", id_pc, 32'h10);
      chk("stall_id_inst", id_inst, mem_word(32'h10));
      chk("stall_mem_req", 32'(mem_req), 32'h0);
      chk("stall_pc_load", 32'(pc_load), 32'h0);
      tick();
    end
    id_ready = 1'b1;
    settle();
    tick();

    // Fetch 0x14, then flush it from HOLD with a redirect to 0x103
    mem_ready = 1'b1; id_ready = 1'b0;
    settle();
    chk("pre_flush_addr", mem_addr, 32'h14);
    sb_pc.push_back(32'h14);
    tick();
    mem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h103;
    settle();
    chk("flush_pc_load", 32'(pc_load), 32'h1);
    chk("flush_pc_d", pc_d, 32'h100);
    void'(sb_pc.pop_front());
    tick();
    redirect = 1'b0;
    settle();
    chk("flush_id_valid", 32'(id_valid), 32'h0);
    chk("flush_mem_req", 32'(mem_req), 32'h1);
    chk("flush_mem_addr", mem_addr, 32'h100);

    // Redirect while request to 0x100 is pending -> DROP
    redirect = 1'b1; redirect_target = 32'h200;
    settle();
    chk("drop_entry_load", 32'(pc_load), 32'h1);
    chk("drop_entry_pc_d", pc_d, 32'h200);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("drop_mem_req", 32'(mem_req), 32'h1);
      chk("drop_mem_addr", mem_addr, 32'h100);
      chk("drop_pc_load", 32'(pc_load), 32'h0);
      tick();
    end
    mem_ready = 1'b1; id_ready = 1'b1;
    settle();
    chk("drop_done_addr", mem_addr, 32'h100);
    chk("drop_done_valid", 32'(id_valid), 32'h0);
    tick();
    settle();
    chk("post_drop_addr", mem_addr, 32'h200);
    sb_pc.push_back(32'h200);
    tick();
    settle();
    chk("post_drop_valid", 32'(id_valid), 32'h1);
    tick();

    // Wrap: align redirect to 0xFFFFFFFC, then sequential next PC wraps to 0
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    settle();
    chk("wrap_redir_pc_d", pc_d, 32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    settle();
    chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_d", pc_d, 32'h0);
    chk("wrap_pc_load", 32'(pc_load), 32'h1);
    sb_pc.push_back(32'hFFFF_FFFC);
    tick();
    settle();
    tick();
    mem_ready = 1'b0;
    settle();
    chk("wrap_next_addr", mem_addr, 32'h0);

    // Reset asserted mid-request
    rst = 1'b0;
    settle();
    chk("rst_mid_pc_load", 32'(pc_load), 32'h0);
    tick();
    settle();
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_id_valid", 32'(id_valid), 32'h0);
    chk("rst_mid_id_inst", id_inst, 32'h0000_0013);
    chk("rst_mid_id_pc", id_pc, 32'h0);
    rst = 1'b1;
    tick();

    chk("sb_leftover", 32'(sb_pc.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
